serial_addsub: RTL and testbench
================================

Name: serial_addsub

Overview:
- Multi-cycle, bit-serial two's-complement adder/subtractor. It processes one bit per clock, LSB first, through a single full-adder slice and a carry flip-flop.
- It is the sequential, area-reduced counterpart of the parallel ripple-carry adder. It computes A+B+CIN or A−B (with CIN acting as the inverted borrow).
- Operands and results have the same width and bit meaning as the RCA, so the same stimulus and golden values apply to both.
- It sits behind a start/busy/done handshake for use by sequenced datapaths.

Parameters:
- data_width, 8, operand/result width in bits (≥2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- SUB  input  1  0 = add, 1 = subtract; latched on accept.
- A  input  data_width  operand A; latched on accept.
- B  input  data_width  operand B; latched on accept.
- CIN  input  1  carry-in (add) / not-borrow-in (sub); latched on accept.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; result valid.
- SUM  output  data_width  result, held until the next accept.
- COUT  output  1  carry-out (add) / not-borrow-out (sub).
- OVF  output  1  signed overflow.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, bit counter=0, internal shift and carry registers=0, busy=0, done=0, SUM=0, COUT=0, OVF=0.
  - rst has priority over every other input.
  - rst during RUN aborts the operation: no done pulse, outputs zeroed.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 → accept. Latch A into shift register a_sr. Latch B into b_sr; when SUB=1, store ~B instead. Set carry=CIN, counter=0, go to RUN.
  - start=0 → stay in IDLE.
- RUN:
  - Each edge: s = a_sr[0]^b_sr[0]^carry; carry ← majority(a_sr[0], b_sr[0], carry); shift s into the MSB of s_sr; shift a_sr and b_sr right; counter++.
  - When processing bit data_width−1, also capture the carry into the MSB (c_msb) for OVF.
  - After the edge processing bit data_width−1: go to DONE.
  - start is ignored in RUN.
- DONE: done=1 for exactly this cycle.
  - start=1 → accept the new operation as in IDLE and go to RUN.
  - start=0 → go to IDLE.
- Result registers:
  - SUM, COUT and OVF update on the same edge that enters DONE: SUM = s_sr, COUT = final carry, OVF = c_msb ^ final carry.
  - They hold their values through IDLE and the following accept until the next DONE.
- Function:
  - {COUT,SUM} = A + B + CIN when SUB=0.
  - {COUT,SUM} = A + ~B + CIN when SUB=1, so CIN=1 gives A−B. COUT=0 means a borrow occurred.
  - All arithmetic is mod 2^data_width.
- Timing:
  - With start accepted at edge t, busy=1 from after edge t through edge t+data_width−1 (data_width cycles).
  - done=1 after edge t+data_width. Latency is data_width cycles.
  - Back-to-back operation is possible: start held high gives one result every data_width+1 cycles.
- busy and done are never high together.
- A, B, SUB and CIN may change freely after accept without affecting the result.

Test Plan:
- Reset, then start with A=0x3C, B=0x5A, CIN=0, SUB=0 → busy high 8 cycles; done pulse 8 cycles after accept; SUM=0x96, COUT=0, OVF=1.
- A=0xFF, B=0x01, CIN=1, SUB=0 → SUM=0x01, COUT=1, OVF=0. Then A=0x05, B=0x07, CIN=1, SUB=1 → SUM=0xFE, COUT=0, OVF=0.
- A=0x80, B=0x01, CIN=1, SUB=1 → SUM=0x7F, COUT=1, OVF=1.
- Start held high continuously with A=0x10, B=0x20, SUB=0, CIN=0 → done every 9 cycles with SUM=0x30.
  - Changing A to 0xFF mid-RUN has no effect on the current result.
  - A start pulse during RUN is ignored.
- rst asserted at cycle 4 of RUN → busy=0, done never pulses, SUM/COUT/OVF=0. A fresh start afterwards completes normally.
- 200 random A, B, CIN, SUB operations → every result matches the reference model {COUT,SUM} and OVF.

Source files
------------

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor: one full-adder slice and a carry
// flop, LSB first, behind a start/busy/done handshake.
module serial_addsub #(
  parameter int unsigned data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  SUB,
  input  logic [data_width-1:0] A,
  input  logic [data_width-1:0] B,
  input  logic                  CIN,
  output logic                  busy,
  output logic                  done,
  output logic [data_width-1:0] SUM,
  output logic                  COUT,
  output logic                  OVF
);

  localparam int unsigned cnt_w = $clog2(data_width);
  localparam logic [cnt_w-1:0] last_bit = cnt_w'(data_width - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                  state;
  state_t                  state_n;
  logic                    accept_c;
  logic                    last_c;
  logic                    s_bit_c;
  logic                    c_next_c;
  logic [data_width-1:0]   a_sr;
  logic [data_width-1:0]   b_sr;
  logic [data_width-1:0]   s_sr;
  logic [cnt_w-1:0]        cnt;
  logic                    carry;

  // Single full-adder slice on the current LSBs
  assign s_bit_c  = a_sr[0] ^ b_sr[0] ^ carry;
  assign c_next_c = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state logic; start is only honoured outside RUN
  always_comb begin
    state_n  = state;
    accept_c = 1'b0;
    last_c   = (cnt == last_bit);
    case (state)
      S_IDLE: begin
        if (start) begin
          accept_c = 1'b1;
          state_n  = S_RUN;
        end
      end
      S_RUN: begin
        if (last_c) state_n = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          accept_c = 1'b1;
          state_n  = S_RUN;
        end else begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Handshake flags follow the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_n == S_RUN);
      done <= (state_n == S_DONE);
    end
  end

  // Serial datapath; subtraction stores ~B so CIN acts as not-borrow
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      s_sr  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      SUM   <= '0;
      COUT  <= 1'b0;
      OVF   <= 1'b0;
    end else if (accept_c) begin
      a_sr  <= A;
      b_sr  <= SUB ? ~B : B;
      carry <= CIN;
      cnt   <= '0;
    end else if (state == S_RUN) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      s_sr  <= {s_bit_c, s_sr[data_width-1:1]};
      carry <= c_next_c;
      cnt   <= cnt + cnt_w'(1);
      if (last_c) begin
        // carry still holds the carry into the MSB here
        SUM  <= {s_bit_c, s_sr[data_width-1:1]};
        COUT <= c_next_c;
        OVF  <= carry ^ c_next_c;
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed and random bench for serial_addsub with a queue-based result scoreboard.
module tb_serial_addsub;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  exp_t         q[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] last_sum = '0;

  serial_addsub #(.data_width(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .SUB   (sub),
    .A     (a),
    .B     (b),
    .CIN   (cin),
    .busy  (busy),
    .done  (done),
    .SUM   (sum),
    .COUT  (cout),
    .OVF   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Negedge step; busy and done must never overlap
  task automatic step();
    @(negedge clk);
    chk("busy_done_excl", 32'(busy & done), 32'd0);
  endtask

  function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                 input logic icin, input logic isub);
    logic [W-1:0] bb;
    logic [W:0]   r;
    exp_t         e;
    bb     = isub ? ~ib : ib;
    r      = {1'b0, ia} + {1'b0, bb} + (W+1)'(icin);
    e.sum  = r[W-1:0];
    e.cout = r[W];
    e.ovf  = (ia[W-1] == bb[W-1]) && (e.sum[W-1] != ia[W-1]);
    return e;
  endfunction

  task automatic pop_check(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = q.pop_front();
      chk({tag, "_sum"},  32'(sum),  32'(e.sum));
      chk({tag, "_cout"}, 32'(cout), 32'(e.cout));
      chk({tag, "_ovf"},  32'(ovf),  32'(e.ovf));
      last_sum = e.sum;
    end
  endtask

  // One operation; mid-RUN the inputs are scrambled and start is pulsed
  task automatic run_op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic icin, input logic isub, input exp_t e);
    int  nbusy;
    int  k;
    bit  seen;
    step();
    a = ia; b = ib; cin = icin; sub = isub; start = 1'b1;
    q.push_back(e);
    nbusy = 0;
    seen  = 1'b0;
    for (k = 1; k <= int'(W) + 6; k++) begin
      step();
      if (k == 1) begin
        start = 1'b0;
        chk({tag, "_sum_held"}, 32'(sum), 32'(last_sum));
      end
      if (k == 3) begin
        start = 1'b1;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      end
      if (k == 4) start = 1'b0;
      if (busy) nbusy++;
      if (done) begin
        seen = 1'b1;
        chk({tag, "_latency"}, 32'(k), 32'(W + 1));
        break;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_busy_cycles"}, 32'(nbusy), 32'(W));
    if (seen) pop_check(tag);
    else q.delete();
  endtask

  initial begin
    exp_t e;
    int   since;
    int   ndone;
    int   k;
    bit   any_done;

    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_sum",  32'(sum),  32'd0);
    chk("reset_cout", 32'(cout), 32'd0);
    chk("reset_ovf",  32'(ovf),  32'd0);

    e = '{sum: 8'h96, cout: 1'b0, ovf: 1'b1}; run_op("add_3c_5a", 8'h3C, 8'h5A, 1'b0, 1'b0, e);
    e = '{sum: 8'h01, cout: 1'b1, ovf: 1'b0}; run_op("add_ff_01", 8'hFF, 8'h01, 1'b1, 1'b0, e);
    e = '{sum: 8'hFE, cout: 1'b0, ovf: 1'b0}; run_op("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b1, e);
    e = '{sum: 8'h7F, cout: 1'b1, ovf: 1'b1}; run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b1, e);

    // Results hold through idle cycles
    for (int i = 0; i < 3; i++) step();
    chk("idle_hold_sum",  32'(sum),  32'h7F);
    chk("idle_hold_cout", 32'(cout), 32'd1);
    chk("idle_hold_ovf",  32'(ovf),  32'd1);

    // Back-to-back with start held high; A disturbed mid-RUN and restored
    step();
    a = 8'h10; b = 8'h20; sub = 1'b0; cin = 1'b0; start = 1'b1;
    for (int i = 0; i < 3; i++) q.push_back('{sum: 8'h30, cout: 1'b0, ovf: 1'b0});
    since = 0;
    ndone = 0;
    for (k = 0; k < 60 && ndone < 3; k++) begin
      step();
      since++;
      if (since == 3) a = 8'hFF;
      if (since == 6) a = 8'h10;
      if (done) begin
        chk("b2b_period", 32'(since), 32'(W + 1));
        pop_check("b2b");
        ndone++;
        since = 0;
        if (ndone == 3) start = 1'b0;
      end
    end
    chk("b2b_count", 32'(ndone), 32'd3);
    q.delete();

    // Reset in the middle of RUN aborts the operation
    step();
    a = 8'h12; b = 8'h34; sub = 1'b0; cin = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum",  32'(sum),  32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_ovf",  32'(ovf),  32'd0);
    any_done = 1'b0;
    for (int i = 0; i < int'(W) + 4; i++) begin
      step();
      if (done || busy) any_done = 1'b1;
    end
    chk("abort_no_activity", 32'(any_done), 32'd0);
    last_sum = '0;
    e = '{sum: 8'h47, cout: 1'b0, ovf: 1'b0}; run_op("after_abort", 8'h12, 8'h34, 1'b1, 1'b0, e);

    // Random operations against the reference model
    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      logic         rs;
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      run_op("rand", ra, rb, rc, rs, model(ra, rb, rc, rs));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
